// File: rtl/alu_op_sequencer.sv
// Multicycle MIPS-subset control FSM.
// Walks each instruction through FETCH/DECODE/execute/memory/writeback,
// issuing the ALU control code and the datapath mux selects and strobes.
// Only the state register and the sticky illegal flag are stored; every
// other output is decoded from the current state (plus funct in EXEC_R
// and zero in BRANCH).
module alu_op_sequencer #(
    parameter int         CTRL_W    = 4,
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              pc_write,
    output logic [1:0]        pc_source,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic [3:0]        state,
    output logic              illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_EXEC_I = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    // ALU control codes
    localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] ALU_NOP = CTRL_W'(4'b1111);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t            state_q;
    state_t            state_d;
    logic              illegal_q;
    logic              illegal_d;

    logic [CTRL_W-1:0] r_ctrl;
    logic              r_legal;
    logic [CTRL_W-1:0] i_ctrl;

    // State register and sticky illegal flag; reset wins even mid-instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= state_t'(RST_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // ALU operation lookup for R-type funct and I-type opcode
    always_comb begin
        r_ctrl  = ALU_NOP;
        r_legal = 1'b1;
        case (funct)
            FN_ADD:  r_ctrl = ALU_ADD;
            FN_SUB:  r_ctrl = ALU_SUB;
            FN_AND:  r_ctrl = ALU_AND;
            FN_OR:   r_ctrl = ALU_OR;
            FN_SLT:  r_ctrl = ALU_SLT;
            default: r_legal = 1'b0;
        endcase

        i_ctrl = ALU_NOP;
        case (opcode)
            OP_ADDI: i_ctrl = ALU_ADD;
            OP_ANDI: i_ctrl = ALU_AND;
            OP_ORI:  i_ctrl = ALU_OR;
            OP_SLTI: i_ctrl = ALU_SLT;
            default: i_ctrl = ALU_NOP;
        endcase
    end

    // Next-state and output decode; anything not set for a state stays 0/NOP
    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        alu_ctrl   = ALU_NOP;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_EXEC_R;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_ctrl;
                if (r_legal) begin
                    state_d = S_RWB;
                end else begin
                    // Unknown funct: drop the instruction, no writeback
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_source = 2'b01;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = i_ctrl;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Table-driven bench for alu_op_sequencer: per-cycle vectors of inputs and
// hand-computed expected state/controls, plus cycle-count sequences.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] state;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_BAD  = 6'b000000;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t vecs[$];

    // {alu_ctrl, src_a, src_b, pc_write, pc_source, iord, mem_read,
    //  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal}
    function automatic logic [17:0] c(input logic [3:0] ac, input logic sa,
                                      input logic [1:0] sb, input logic pw,
                                      input logic [1:0] ps, input logic io,
                                      input logic mr, input logic mw,
                                      input logic iw, input logic rd,
                                      input logic m2r, input logic rw,
                                      input logic il);
        return {ac, sa, sb, pw, ps, io, mr, mw, iw, rd, m2r, rw, il};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] s, input logic [17:0] k);
        vec_t v;
        v.rst = r; v.op = o; v.fn = f; v.z = z; v.st = s; v.ctl = k;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] actual_ctl();
        return {alu_ctrl, alu_src_a, alu_src_b, pc_write, pc_source, iord,
                mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                illegal};
    endfunction

    task automatic check_val(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s #%0d actual=%h expected=%h", name, idx, act, exp);
        end else begin
            $display("ok   %s #%0d value=%h", name, idx, act);
        end
    endtask

    // Run one instruction from FETCH and count cycles until FETCH returns
    task automatic run_instr(input string name, input logic [5:0] o,
                             input logic [5:0] f, input int exp_cycles);
        int n;
        opcode = o;
        funct  = f;
        zero   = 1'b0;
        n      = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== 4'd0 && n < 20);
        check_val(name, exp_cycles, n, exp_cycles);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- vector table ----------------
        // sub (R-type)
        add(0, OP_R, FN_SUB, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_SUB, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_SUB, 0, 6, c(4'b0110,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_SUB, 0, 7, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0));
        // lw
        add(0, OP_LW, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 2, c(4'b0010,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 3, c(4'b1111,0,2'b00,0,2'b00,1,1,0,0,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 4, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,0,1,1,0));
        // sw
        add(0, OP_SW, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_SW, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_SW, FN_ADD, 0, 2, c(4'b0010,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_SW, FN_ADD, 0, 5, c(4'b1111,0,2'b00,0,2'b00,1,0,1,0,0,0,0,0));
        // beq taken
        add(0, OP_BEQ, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_BEQ, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_BEQ, FN_ADD, 1, 8, c(4'b0110,1,2'b00,1,2'b01,0,0,0,0,0,0,0,0));
        // beq not taken, zero pulsed outside BRANCH
        add(0, OP_BEQ, FN_ADD, 1, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_BEQ, FN_ADD, 1, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_BEQ, FN_ADD, 0, 8, c(4'b0110,1,2'b00,0,2'b01,0,0,0,0,0,0,0,0));
        // j
        add(0, OP_J, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_J, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_J, FN_ADD, 0, 9, c(4'b1111,0,2'b00,1,2'b10,0,0,0,0,0,0,0,0));
        // add / and / or / slt (R-type), EXEC_R rows carry the code
        add(0, OP_R, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_ADD, 0, 6, c(4'b0010,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_ADD, 0, 7, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0));
        add(0, OP_R, FN_AND, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_AND, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_AND, 0, 6, c(4'b0000,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_AND, 0, 7, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0));
        add(0, OP_R, FN_OR,  0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_OR,  0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_OR,  0, 6, c(4'b0001,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_OR,  0, 7, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0));
        add(0, OP_R, FN_SLT, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_SLT, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_SLT, 0, 6, c(4'b0111,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_SLT, 0, 7, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,1,0,1,0));
        // ori / andi / slti
        add(0, OP_ORI,  FN_ADD, 0, 0,  c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_ORI,  FN_ADD, 0, 1,  c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_ORI,  FN_ADD, 0, 10, c(4'b0001,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_ORI,  FN_ADD, 0, 11, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,0,0,1,0));
        add(0, OP_ANDI, FN_ADD, 0, 0,  c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_ANDI, FN_ADD, 0, 1,  c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_ANDI, FN_ADD, 0, 10, c(4'b0000,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_ANDI, FN_ADD, 0, 11, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,0,0,1,0));
        add(0, OP_SLTI, FN_ADD, 0, 0,  c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_SLTI, FN_ADD, 0, 1,  c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_SLTI, FN_ADD, 0, 10, c(4'b0111,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_SLTI, FN_ADD, 0, 11, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,0,0,1,0));
        // illegal opcode, then addi with illegal held
        add(0, OP_BAD,  FN_ADD, 0, 0,  c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_BAD,  FN_ADD, 0, 1,  c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_ADDI, FN_ADD, 0, 0,  c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,1));
        add(0, OP_ADDI, FN_ADD, 0, 1,  c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,1));
        add(0, OP_ADDI, FN_ADD, 0, 10, c(4'b0010,1,2'b10,0,2'b00,0,0,0,0,0,0,0,1));
        add(0, OP_ADDI, FN_ADD, 0, 11, c(4'b1111,0,2'b00,0,2'b00,0,0,0,0,0,0,1,1));
        // rst in FETCH: outputs still pre-edge (illegal=1), cleared after
        add(1, OP_LW, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,1));
        // lw with rst in MEMRD
        add(0, OP_LW, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_LW, FN_ADD, 0, 2, c(4'b0010,1,2'b10,0,2'b00,0,0,0,0,0,0,0,0));
        add(1, OP_LW, FN_ADD, 0, 3, c(4'b1111,0,2'b00,0,2'b00,1,1,0,0,0,0,0,0));
        // illegal funct: NOP in EXEC_R, skip RWB, illegal set
        add(0, OP_R, FN_BAD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0));
        add(0, OP_R, FN_BAD, 0, 1, c(4'b0010,0,2'b11,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_R, FN_BAD, 0, 6, c(4'b1111,1,2'b00,0,2'b00,0,0,0,0,0,0,0,0));
        add(0, OP_J, FN_ADD, 0, 0, c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,1));

        // ---------------- reset: 2 cycles high ----------------
        rst    = 1'b1;
        opcode = OP_R;
        funct  = FN_SUB;
        zero   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("reset_state", 0, 32'(state), 32'd0);
        check_val("reset_ctl", 0, 32'(actual_ctl()),
                  32'(c(4'b0010,0,2'b01,1,2'b00,0,1,0,1,0,0,0,0)));

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].z;
            #1;
            check_val("state", i, 32'(state), 32'(vecs[i].st));
            check_val("ctl", i, 32'(actual_ctl()), 32'(vecs[i].ctl));
        end

        // ---------------- cycle counts ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("seq_reset_state", 0, 32'(state), 32'd0);
        run_instr("cycles_lw",   OP_LW,   FN_ADD, 5);
        run_instr("cycles_sw",   OP_SW,   FN_ADD, 4);
        run_instr("cycles_r",    OP_R,    FN_ADD, 4);
        run_instr("cycles_addi", OP_ADDI, FN_ADD, 4);
        run_instr("cycles_beq",  OP_BEQ,  FN_ADD, 3);
        run_instr("cycles_j",    OP_J,    FN_ADD, 3);
        check_val("illegal_clear", 0, 32'(illegal), 32'd0);
        run_instr("cycles_badop", OP_BAD, FN_ADD, 2);
        check_val("illegal_op_set", 0, 32'(illegal), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("illegal_rst", 0, 32'(illegal), 32'd0);
        run_instr("cycles_badfn", OP_R, FN_BAD, 3);
        check_val("illegal_fn_set", 0, 32'(illegal), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multicycle MIPS-subset control FSM.
- Initiator side of the ALU operation interface: it issues the 4-bit ALU control code each cycle and consumes the ALU Zero flag.
- Also drives the datapath mux selects and write enables for fetch, decode, execute, memory and writeback.
- Sits between the instruction register and the shared single-ALU datapath.

Parameters:
- CTRL_W, 4, ALU control code width.
- RST_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH.
- funct  in  6  IR[5:0], same stability as opcode.
- zero  in  1  ALU Zero flag, sampled in BRANCH.
- alu_ctrl  out  4  AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOP=1111.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- pc_write  out  1  PC load enable (unconditional, or branch taken).
- pc_source  out  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- iord  out  1  0=PC address, 1=ALUOut address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- state  out  4  current state, for debug.
- illegal  out  1  sticky illegal-instruction flag.

Behaviour:
- The state register and the illegal flag are the only flops. All other outputs are decoded from state (Moore). Exceptions: alu_ctrl in EXEC_R also depends on funct; pc_write in BRANCH also depends on zero.
- Outputs not listed for a state are 0.
- States:
  - FETCH (0): mem_read, ir_write, alu_src_a=0, alu_src_b=01, ADD, pc_write, pc_source=00. Next: DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC_R; 000100 -> BRANCH; 000010 -> JUMP; 001000/001100/001101/001010 -> EXEC_I; any other -> FETCH with illegal set.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, ADD. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_read, iord=1. Next: MEMWB.
  - MEMWB (4): reg_write, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR (5): mem_write, iord=1. Next: FETCH.
  - EXEC_R (6): alu_src_a=1, alu_src_b=00, alu_ctrl by funct:
    - 100000=ADD, 100010=SUB, 100100=AND, 100101=OR, 101010=SLT.
    - Other funct: NOP, illegal set, next FETCH with no writeback.
    - Legal funct: next RWB.
  - RWB (7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write=zero. Next: FETCH.
  - JUMP (9): pc_write, pc_source=10, alu_ctrl=NOP. Next: FETCH.
  - EXEC_I (10): alu_src_a=1, alu_src_b=10. alu_ctrl by opcode: addi=ADD, andi=AND, ori=OR, slti=SLT. Next: IWB.
  - IWB (11): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - States 12-15: all outputs 0, alu_ctrl=NOP, next FETCH.
- alu_ctrl is NOP in every state not listed above with an ALU operation.
- Cycle counts per instruction: lw 5; sw, R-type, I-type 4; beq, j 3; illegal opcode 2; illegal funct 3.
- Reset:
  - rst sampled high on any clock edge forces state=FETCH and illegal=0, even mid-instruction.
  - During the cycle rst is high, outputs reflect the pre-edge state. From the first cycle after the edge, outputs are FETCH values.
- illegal stays set until rst. It has no effect on sequencing beyond returning to FETCH.
- Branch: zero is sampled only in BRANCH. A zero pulse in any other state has no effect.
- Strobe exclusivity: mem_read and mem_write are never both high. ir_write is high only in FETCH.

Test Plan:
- rst high 2 cycles, then low -> state=0, mem_read=1, ir_write=1, pc_write=1, alu_ctrl=0010, alu_src_b=01, illegal=0.
- opcode=000000, funct=100010 -> states 0,1,6,7,0; alu_ctrl=0110 in EXEC_R; reg_write=1, reg_dst=1 in RWB.
- opcode=100011 -> states 0,1,2,3,4; iord=1 in MEMRD; reg_write=1, mem_to_reg=1 in MEMWB. Then opcode=101011 -> 0,1,2,5, with mem_write=1 only in MEMWR.
- opcode=000100 with zero=1 -> pc_write=1, pc_source=01, alu_ctrl=0110 in BRANCH. Repeat with zero=0 -> pc_write=0 in BRANCH.
- opcode=111111 -> DECODE then FETCH, illegal=1 and held through a following addi (0,1,10,11). funct=000000 R-type -> alu_ctrl=1111, skips RWB.
- rst asserted in MEMRD -> next cycle state=0, illegal=0, mem_write=0, reg_write=0.
